keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Controller that sequences a 4x4 matrix keypad. It drives one column low at a time and samples the four row lines. It debounces the press and release of the detected key with a fixed stable-time window, then emits a one-cycle key event with a 4-bit key code. It sits between the keypad pins and the input/command logic, and replaces per-line debouncing for the matrix.

Parameters:
CLK_FREQ, 27_000_000, system clock frequency in Hz
DEBOUNCE_TIME_MS, 20, required stable time in ms; DB_CYCLES = (CLK_FREQ/1000)*DEBOUNCE_TIME_MS, must be >= 2
SCAN_DIV, 27_000, clock cycles each column is driven during scanning; must be >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
row_in  input  4  keypad row lines, active-low (pulled up), asynchronous to clk
col_out  output  4  keypad column drive, one-hot active-low
key_valid  output  1  one-cycle pulse: new debounced key press
key_code  output  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}
key_pressed  output  1  level: a debounced key is currently held

Behaviour:
- row_in passes through a 2-flop synchronizer (rows_s); all decisions use rows_s.
- One clock and one reset. Reset is synchronous and active-high: it is sampled only on the rising edge of clk and takes priority over all other logic.
- On reset: state=SCAN, col_idx=0, col_out=4'b1110, key_valid=0, key_code=0, key_pressed=0, all counters 0, synchronizer flops=4'hF.
- col_out = ~(4'b0001 << col_idx) in every state. The column is frozen outside SCAN.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - dwell counter counts 0..SCAN_DIV-1.
  - Rows are sampled only on the cycle where the counter equals SCAN_DIV-1 (the sample cycle).
  - If rows_s==4'hF: col_idx increments (3 wraps to 0) and the counter returns to 0.
  - Otherwise: latch rows_s into row_pat, go to DEBOUNCE, load db counter with DB_CYCLES-1.
- DEBOUNCE:
  - Each cycle, compare rows_s with row_pat.
  - Mismatch: go to SCAN with col_idx+1 and dwell counter 0. No event.
  - Match with db counter==0: go to PRESSED.
  - Otherwise the db counter decrements.
- Entry to PRESSED:
  - key_valid=1 for exactly the first PRESSED cycle; registered output.
  - key_code = {row_enc, col_idx}, where row_enc is the index of the lowest zero bit of row_pat (lowest row wins when several rows are low).
  - key_pressed=1.
- Latency: with the sample cycle at T, key_valid is high at T+DB_CYCLES+1.
- PRESSED: when rows_s==4'hF, go to RELEASE and load the db counter with DB_CYCLES-1. Any other pattern (including a second key) is ignored.
- RELEASE:
  - rows_s!=4'hF: return to PRESSED with no new key_valid; key_pressed stays 1.
  - rows_s==4'hF with db counter==0: go to SCAN, key_pressed=0, col_idx+1, dwell counter 0.
  - Otherwise the db counter decrements.
- key_code holds its value until the next accepted press. It is cleared only by reset.
- Reset asserted in any state aborts the operation: the next cycle shows the full reset values. No key_valid is generated for an interrupted debounce.
- Counter widths are sized by $clog2 of their maximum. No overflow is possible.

Test Plan:
(Bench parameters: CLK_FREQ=1000, DEBOUNCE_TIME_MS=8 giving DB_CYCLES=8, SCAN_DIV=4. The keypad model pulls row r low while key (r,c) is held and col_out[c]==0.)
1. Reset, no key -> col_out=1110 and all outputs 0; then col_out steps 1110,1101,1011,0111,1110 every 4 cycles with no key_valid.
2. Hold key (2,1) -> exactly one key_valid pulse, key_code=4'h9, key_pressed=1, col_out frozen at 1101; no further pulse over 100 held cycles.
3. Key (0,3) bounces, stable for only 5 cycles then released -> no key_valid, key_pressed stays 0, scanning resumes with col_out=1110.
4. Key (1,0) held, then released for 3 cycles, pressed again, then released for 12 cycles -> a single key_valid (code 4'h4). key_pressed falls 9 cycles after the final release reaches rows_s, and scanning resumes at col_out=1101.
5. Keys (1,2) and (3,2) held together -> key_code=4'h6 (lowest row wins), one pulse.
6. Reset pulsed during DEBOUNCE of key (3,3) -> next cycle col_out=1110, key_valid=0, key_code=0, key_pressed=0. Holding the key afterwards produces a fresh pulse with code 4'hF.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
// ---------------------------------------------------------------------------
// Scans a 4x4 active-low matrix keypad one column at a time. A key press found
// during scanning must stay stable for DB_CYCLES clocks before it is accepted.
// An accepted press produces a one-cycle key_valid pulse and latches key_code.
// The key is then tracked until a release has also been stable for DB_CYCLES
// clocks, and after that scanning resumes on the next column.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   row_in[3:0]  keypad row lines, active-low, asynchronous to clk
//   col_out[3:0] keypad column drive, one-hot active-low
//   key_valid    one-cycle pulse on each newly accepted key press
//   key_code     {row_idx, col_idx} of the last accepted key
//   key_pressed  high while a debounced key is held
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int CLK_FREQ         = 27_000_000,
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int SCAN_DIV         = 27_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    localparam int DB_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_TIME_MS;
    localparam int DW_W      = $clog2(SCAN_DIV);
    localparam int DB_W      = $clog2(DB_CYCLES);

    localparam logic [DW_W-1:0] DWELL_MAX  = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0] DWELL_ZERO = {DW_W{1'b0}};
    localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1);
    localparam logic [DB_W-1:0] DB_MAX     = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ZERO    = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the lowest low row; the lowest row wins when several are low.
    function automatic logic [1:0] row_enc_f(input logic [3:0] pat);
        logic [1:0] idx;
        if (!pat[0]) begin
            idx = 2'd0;
        end else if (!pat[1]) begin
            idx = 2'd1;
        end else if (!pat[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Synchronizer and state
    logic [3:0]      sync_meta_r;
    logic [3:0]      rows_s;
    state_t          state_r;
    logic [1:0]      col_idx_r;
    logic [DW_W-1:0] dwell_r;
    logic [DB_W-1:0] db_cnt_r;
    logic [3:0]      row_pat_r;
    logic [3:0]      col_out_r;
    logic            key_valid_r;
    logic [3:0]      key_code_r;
    logic            key_pressed_r;

    // Next-state values
    state_t          state_s;
    logic [1:0]      col_idx_s;
    logic [DW_W-1:0] dwell_s;
    logic [DB_W-1:0] db_cnt_s;
    logic [3:0]      row_pat_s;
    logic [3:0]      col_out_s;
    logic            key_valid_s;
    logic [3:0]      key_code_s;
    logic            key_pressed_s;

    // Two-flop synchronizer for the asynchronous row lines; idle rows read high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 4'hF;
            rows_s      <= 4'hF;
        end else begin
            sync_meta_r <= row_in;
            rows_s      <= sync_meta_r;
        end
    end

    // State register: FSM state, scan/debounce datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_SCAN;
            col_idx_r     <= 2'd0;
            dwell_r       <= DWELL_ZERO;
            db_cnt_r      <= DB_ZERO;
            row_pat_r     <= 4'hF;
            col_out_r     <= 4'b1110;
            key_valid_r   <= 1'b0;
            key_code_r    <= 4'h0;
            key_pressed_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            col_idx_r     <= col_idx_s;
            dwell_r       <= dwell_s;
            db_cnt_r      <= db_cnt_s;
            row_pat_r     <= row_pat_s;
            col_out_r     <= col_out_s;
            key_valid_r   <= key_valid_s;
            key_code_r    <= key_code_s;
            key_pressed_r <= key_pressed_s;
        end
    end

    // Next-state logic: column dwell, press qualification and release tracking.
    always_comb begin
        state_s   = state_r;
        col_idx_s = col_idx_r;
        dwell_s   = dwell_r;
        db_cnt_s  = db_cnt_r;
        row_pat_s = row_pat_r;
        case (state_r)
            ST_SCAN: begin
                // Rows are only looked at on the last dwell cycle, by which time
                // the synchronizer holds values taken while this column was driven.
                if (dwell_r == DWELL_MAX) begin
                    dwell_s = DWELL_ZERO;
                    if (rows_s == 4'hF) begin
                        col_idx_s = col_idx_r + 2'd1;
                    end else begin
                        row_pat_s = rows_s;
                        db_cnt_s  = DB_MAX;
                        state_s   = ST_DEBOUNCE;
                    end
                end else begin
                    dwell_s = dwell_r + DWELL_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (rows_s != row_pat_r) begin
                    state_s   = ST_SCAN;
                    col_idx_s = col_idx_r + 2'd1;
                    dwell_s   = DWELL_ZERO;
                end else if (db_cnt_r == DB_ZERO) begin
                    state_s = ST_PRESSED;
                end else begin
                    db_cnt_s = db_cnt_r - DB_ONE;
                end
            end
            ST_PRESSED: begin
                // Only an all-released pattern matters here; extra keys are ignored.
                if (rows_s == 4'hF) begin
                    state_s  = ST_RELEASE;
                    db_cnt_s = DB_MAX;
                end else begin
                    state_s = ST_PRESSED;
                end
            end
            ST_RELEASE: begin
                if (rows_s != 4'hF) begin
                    state_s = ST_PRESSED;
                end else if (db_cnt_r == DB_ZERO) begin
                    state_s   = ST_SCAN;
                    col_idx_s = col_idx_r + 2'd1;
                    dwell_s   = DWELL_ZERO;
                end else begin
                    db_cnt_s = db_cnt_r - DB_ONE;
                end
            end
            default: begin
                state_s   = ST_SCAN;
                col_idx_s = 2'd0;
                dwell_s   = DWELL_ZERO;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        key_valid_s   = 1'b0;
        key_code_s    = key_code_r;
        key_pressed_s = 1'b0;
        col_out_s     = ~(4'b0001 << col_idx_s);
        // The pulse and code are produced on the same edge that enters PRESSED.
        if ((state_r == ST_DEBOUNCE) && (rows_s == row_pat_r) && (db_cnt_r == DB_ZERO)) begin
            key_valid_s = 1'b1;
            key_code_s  = {row_enc_f(row_pat_r), col_idx_r};
        end else begin
            key_valid_s = 1'b0;
        end
        if ((state_s == ST_PRESSED) || (state_s == ST_RELEASE)) begin
            key_pressed_s = 1'b1;
        end else begin
            key_pressed_s = 1'b0;
        end
    end

    assign col_out     = col_out_r;
    assign key_valid   = key_valid_r;
    assign key_code    = key_code_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives keypad_scanner with a keypad model (row r pulled low while key (r,c)
// is held and column c is driven low) and compares every cycle against a
// phase/run-length reference model, plus directed checks for each scenario.
module tb_keypad_scanner;

    localparam int CLK_FREQ         = 1000;
    localparam int DEBOUNCE_TIME_MS = 8;
    localparam int SCAN_DIV         = 4;
    localparam int DB_CYCLES        = (CLK_FREQ / 1000) * DEBOUNCE_TIME_MS;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [15:0] keys;

    int vec_cnt = 0;
    int err_cnt = 0;
    int pulses  = 0;
    int fall_k  = 0;

    // Reference model: phase 0 scanning, 1 qualifying a press, 2 key held
    int         m_phase  = 0;
    int         m_col    = 0;
    int         m_scan_t = 0;
    int         m_seen   = 0;
    int         m_frun   = 0;
    logic [3:0] m_cand   = 4'hF;
    logic [3:0] m_rs1    = 4'hF;
    logic [3:0] m_rs2    = 4'hF;
    logic [3:0] exp_col     = 4'b1110;
    logic       exp_valid   = 1'b0;
    logic [3:0] exp_code    = 4'h0;
    logic       exp_pressed = 1'b0;
    logic [3:0] col_tab [4];

    always #5 clk = ~clk;

    keypad_scanner #(
        .CLK_FREQ        (CLK_FREQ),
        .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS),
        .SCAN_DIV        (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_pressed(key_pressed)
    );

    function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] cols);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (k[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
        return rows;
    endfunction

    assign row_in = keypad_rows(keys, col_out);

    function automatic logic [1:0] lowest_row(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Advance the model by one clock using the rows value seen this cycle.
    task automatic model_step();
        logic [3:0] r;
        logic [3:0] row_now;
        row_now = keypad_rows(keys, exp_col);
        r = m_rs2;
        if (reset) begin
            m_phase = 0; m_col = 0; m_scan_t = 0; m_seen = 0; m_frun = 0;
            m_cand = 4'hF; m_rs1 = 4'hF; m_rs2 = 4'hF;
            exp_valid = 1'b0; exp_code = 4'h0; exp_pressed = 1'b0;
        end else begin
            m_rs2 = m_rs1;
            m_rs1 = row_now;
            exp_valid = 1'b0;
            if (m_phase == 0) begin
                if (m_scan_t == SCAN_DIV - 1) begin
                    m_scan_t = 0;
                    if (r == 4'hF) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        m_cand = r; m_seen = 0; m_phase = 1;
                    end
                end else begin
                    m_scan_t++;
                end
            end else if (m_phase == 1) begin
                if (r != m_cand) begin
                    m_phase = 0; m_col = (m_col + 1) % 4; m_scan_t = 0;
                end else begin
                    m_seen++;
                    if (m_seen == DB_CYCLES) begin
                        m_phase = 2; m_frun = 0;
                        exp_valid = 1'b1; exp_pressed = 1'b1;
                        exp_code = {lowest_row(m_cand), m_col[1:0]};
                    end
                end
            end else begin
                if (r == 4'hF) m_frun++; else m_frun = 0;
                if (m_frun == DB_CYCLES + 1) begin
                    m_phase = 0; m_col = (m_col + 1) % 4; m_scan_t = 0;
                    exp_pressed = 1'b0;
                end
            end
        end
        exp_col = 4'hF;
        exp_col[m_col] = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) pulses++;
        check("col_out",     {4'h0, col_out},     {4'h0, exp_col});
        check("key_valid",   {7'h0, key_valid},   {7'h0, exp_valid});
        check("key_code",    {4'h0, key_code},    {4'h0, exp_code});
        check("key_pressed", {7'h0, key_pressed}, {7'h0, exp_pressed});
    endtask

    task automatic wait_phase(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (m_phase != target && n < limit) begin
            tick();
            n++;
        end
        check(tag, 8'(m_phase), 8'(target));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        col_tab[0] = 4'b1110; col_tab[1] = 4'b1101;
        col_tab[2] = 4'b1011; col_tab[3] = 4'b0111;
        reset = 1'b1;
        keys  = 16'h0;

        // 1. reset state, then column stepping with no key
        tick();
        check("rst_col",     {4'h0, col_out}, 8'h0E);
        check("rst_valid",   {7'h0, key_valid}, 8'h00);
        check("rst_code",    {4'h0, key_code}, 8'h00);
        check("rst_pressed", {7'h0, key_pressed}, 8'h00);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 4 == 3) check("t1_col_step", {4'h0, col_out}, {4'h0, col_tab[((i + 1) / 4) % 4]});
        end
        check("t1_pulses", 8'(pulses), 8'd0);

        // 2. hold key (2,1)
        pulses = 0;
        keys = 16'h1 << 9;
        wait_phase(2, 100, "t2_wait");
        idle(100);
        check("t2_pulses",  8'(pulses), 8'd1);
        check("t2_code",    {4'h0, key_code}, 8'h09);
        check("t2_pressed", {7'h0, key_pressed}, 8'h01);
        check("t2_col",     {4'h0, col_out}, 8'h0D);
        keys = 16'h0;
        idle(20);
        check("t2_released", {7'h0, key_pressed}, 8'h00);

        // 3. key (0,3) too short to qualify
        pulses = 0;
        keys = 16'h1 << 3;
        wait_phase(1, 40, "t3_wait");
        idle(4);
        keys = 16'h0;
        wait_phase(0, 20, "t3_back");
        check("t3_col", {4'h0, col_out}, 8'h0E);
        idle(10);
        check("t3_pulses",  8'(pulses), 8'd0);
        check("t3_pressed", {7'h0, key_pressed}, 8'h00);

        // 4. key (1,0) with a short release gap, then a long release
        pulses = 0;
        keys = 16'h1 << 4;
        wait_phase(2, 40, "t4_wait");
        idle(10);
        keys = 16'h0;
        idle(3);
        keys = 16'h1 << 4;
        idle(10);
        keys = 16'h0;
        fall_k = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (fall_k == 0 && key_pressed === 1'b0) fall_k = k;
            if (k == 11) check("t4_col", {4'h0, col_out}, 8'h0D);
        end
        check("t4_fall",   8'(fall_k), 8'd11);
        check("t4_pulses", 8'(pulses), 8'd1);
        check("t4_code",   {4'h0, key_code}, 8'h04);

        // 5. keys (1,2) and (3,2) together
        pulses = 0;
        keys = (16'h1 << 6) | (16'h1 << 14);
        wait_phase(2, 40, "t5_wait");
        idle(20);
        check("t5_pulses", 8'(pulses), 8'd1);
        check("t5_code",   {4'h0, key_code}, 8'h06);
        keys = 16'h0;
        idle(20);

        // 6. reset during qualification of key (3,3)
        keys = 16'h1 << 15;
        wait_phase(1, 40, "t6_wait_db");
        idle(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_col",     {4'h0, col_out}, 8'h0E);
        check("t6_valid",   {7'h0, key_valid}, 8'h00);
        check("t6_code",    {4'h0, key_code}, 8'h00);
        check("t6_pressed", {7'h0, key_pressed}, 8'h00);
        pulses = 0;
        wait_phase(2, 60, "t6_wait");
        idle(5);
        check("t6_pulses",   8'(pulses), 8'd1);
        check("t6_code_new", {4'h0, key_code}, 8'h0F);
        keys = 16'h0;
        idle(20);

        // Randomized presses with bounce, checked cycle by cycle by the model
        for (int it = 0; it < 40; it++) begin
            int nk;
            int hold;
            int rel;
            logic [15:0] k;
            k = 16'h0;
            nk = int'($urandom_range(0, 2));
            for (int j = 0; j < nk; j++) k[$urandom_range(0, 15)] = 1'b1;
            hold = int'($urandom_range(0, 40));
            for (int i = 0; i < hold; i++) begin
                if ($urandom_range(0, 9) == 0) keys = 16'h0;
                else keys = k;
                tick();
            end
            keys = 16'h0;
            rel = int'($urandom_range(0, 25));
            idle(rel);
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
